// File: rtl/vga_fb_if.sv
// Command/response and framebuffer bundle between the core and vga_fb_ctrl.
interface vga_fb_if #(
  parameter int unsigned COLS = 10,
  parameter int unsigned ROWS = 10
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [3:0]           cmd_x;
  logic [3:0]           cmd_y;
  logic [COLS-1:0]      cmd_row;
  logic                 rsp_valid;
  logic                 rsp_pixel;
  logic                 rsp_err;
  logic                 busy;
  logic [COLS*ROWS-1:0] video_memory;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_row,
    input  cmd_ready, rsp_valid, rsp_pixel, rsp_err, busy, video_memory
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_row,
    output cmd_ready, rsp_valid, rsp_pixel, rsp_err, busy, video_memory
  );
endinterface

// File: rtl/vga_fb_ctrl.sv
// Monochrome COLS x ROWS framebuffer with pixel/row/clear/scroll command port.
// Optional multi-cycle scroll-up is built only when VGA_FB_SCROLL_EN is defined.
module vga_fb_ctrl #(
  parameter int unsigned COLS = 10,
  parameter int unsigned ROWS = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  vga_fb_if.slave  bus
);
  localparam int unsigned N  = COLS * ROWS;
  localparam int unsigned IW = $clog2(N + 1);
  localparam int unsigned CW = $clog2(ROWS);

  typedef enum logic [1:0] {
    StIdle,
`ifdef VGA_FB_SCROLL_EN
    StScroll,
`endif
    StClear
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    mem_q, mem_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_pixel_q, rsp_pixel_d;
  logic            rsp_err_q, rsp_err_d;
`ifdef VGA_FB_SCROLL_EN
  logic [COLS-1:0] fill_q, fill_d;
  logic [COLS-1:0] next_row;
`endif

  logic          accept, pix_oor, row_oor, last_row;
  logic [IW-1:0] idx, ybase, cbase;

  assign accept   = bus.cmd_valid && (state_q == StIdle);
  assign pix_oor  = (32'(bus.cmd_x) >= COLS) || (32'(bus.cmd_y) >= ROWS);
  assign row_oor  = 32'(bus.cmd_y) >= ROWS;
  assign ybase    = IW'(bus.cmd_y) * IW'(COLS);
  assign idx      = ybase + IW'(bus.cmd_x);
  assign cbase    = IW'(cnt_q) * IW'(COLS);
  assign last_row = cnt_q == CW'(ROWS - 1);
`ifdef VGA_FB_SCROLL_EN
  assign next_row = COLS'(mem_q >> (cbase + IW'(COLS)));
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_d       = mem_q;
    rsp_valid_d = 1'b0;
    rsp_pixel_d = rsp_pixel_q;
    rsp_err_d   = rsp_err_q;
`ifdef VGA_FB_SCROLL_EN
    fill_d      = fill_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_pixel_d = 1'b0;
          rsp_err_d   = 1'b0;
          case (bus.cmd_op)
            3'd1, 3'd2, 3'd3, 3'd4: begin
              if (pix_oor) begin
                rsp_err_d = 1'b1;
              end else begin
                case (bus.cmd_op)
                  3'd1:    mem_d[idx] = 1'b1;
                  3'd2:    mem_d[idx] = 1'b0;
                  3'd3:    mem_d[idx] = ~mem_q[idx];
                  default: rsp_pixel_d = mem_q[idx];
                endcase
              end
            end
            3'd5: begin
              if (row_oor) rsp_err_d = 1'b1;
              else         mem_d[ybase +: COLS] = bus.cmd_row;
            end
            3'd6: begin
              rsp_valid_d = 1'b0;
              state_d     = StClear;
            end
            3'd7: begin
`ifdef VGA_FB_SCROLL_EN
              rsp_valid_d = 1'b0;
              fill_d      = bus.cmd_row;
              state_d     = StScroll;
`else
              rsp_err_d   = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      StClear: begin
        mem_d[cbase +: COLS] = '0;
        if (last_row) begin
          state_d     = StIdle;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_pixel_d = 1'b0;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef VGA_FB_SCROLL_EN
      StScroll: begin
        // Row r pulls from r+1 before r+1 is itself overwritten on the next cycle.
        mem_d[cbase +: COLS] = last_row ? fill_q : next_row;
        if (last_row) begin
          state_d     = StIdle;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_pixel_d = 1'b0;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_pixel_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef VGA_FB_SCROLL_EN
      fill_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pixel_q <= rsp_pixel_d;
      rsp_err_q   <= rsp_err_d;
`ifdef VGA_FB_SCROLL_EN
      fill_q      <= fill_d;
`endif
    end
  end

  assign bus.cmd_ready    = state_q == StIdle;
  assign bus.busy         = state_q != StIdle;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_pixel    = rsp_pixel_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.video_memory = mem_q;
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Randomized self-checking bench for vga_fb_ctrl against a row/column array model.
module tb_vga_fb_ctrl;
  localparam int unsigned COLS = 10;
  localparam int unsigned ROWS = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_fb_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  vga_fb_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit mdl [ROWS][COLS];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] flat();
    logic [127:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) v[r*COLS+c] = mdl[r][c];
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mdl[r][c] = 1'b0;
  endtask

  // Applies one command to the model; returns expected err, pixel and busy-cycle count.
  task automatic model_cmd(input int op, input int x, input int y, input logic [COLS-1:0] row,
                           output logic err, output logic pix, output int lat);
    err = 1'b0; pix = 1'b0; lat = 0;
    case (op)
      1, 2, 3, 4: begin
        if (x >= COLS || y >= ROWS) err = 1'b1;
        else if (op == 1) mdl[y][x] = 1'b1;
        else if (op == 2) mdl[y][x] = 1'b0;
        else if (op == 3) mdl[y][x] = !mdl[y][x];
        else pix = mdl[y][x];
      end
      5: begin
        if (y >= ROWS) err = 1'b1;
        else for (int c = 0; c < COLS; c++) mdl[y][c] = row[c];
      end
      6: begin
        model_clear();
        lat = ROWS;
      end
      7: begin
`ifdef VGA_FB_SCROLL_EN
        for (int r = 0; r < ROWS - 1; r++) mdl[r] = mdl[r+1];
        for (int c = 0; c < COLS; c++) mdl[ROWS-1][c] = row[c];
        lat = ROWS;
`else
        err = 1'b1;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic do_cmd(input int op, input int x, input int y, input logic [COLS-1:0] row);
    logic e, p;
    int lat, n;
    model_cmd(op, x, y, row, e, p, lat);
    @(negedge clk);
    bus.cmd_op = 3'(op); bus.cmd_x = 4'(x); bus.cmd_y = 4'(y); bus.cmd_row = row;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < ROWS + 4) begin
      check_eq("busy_ready", {bus.busy, bus.cmd_ready}, 2'b10);
      @(posedge clk); #1;
      n++;
    end
    check_eq("rsp_valid", bus.rsp_valid, 1'b1);
    check_eq("latency", n, lat);
    check_eq("video_memory", bus.video_memory, flat());
    check_eq("rsp_err", bus.rsp_err, e);
    check_eq("rsp_pixel", bus.rsp_pixel, p);
    check_eq("ready_after", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    check_eq("rsp_pulse", bus.rsp_valid, 1'b0);
    check_eq("rsp_err_hold", bus.rsp_err, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic e, p;
    int lat;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_row = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem", bus.video_memory, '0);
    check_eq("rst_ready", bus.cmd_ready, 1'b1);
    check_eq("rst_rsp", {bus.rsp_valid, bus.rsp_pixel, bus.rsp_err, bus.busy}, 4'b0);
    @(negedge clk); rst_n = 1'b1;

    do_cmd(1, 3, 2, '0);
    check_eq("bit23_set", bus.video_memory[23], 1'b1);
    do_cmd(3, 3, 2, '0);
    check_eq("bit23_tog", bus.video_memory[23], 1'b0);
    do_cmd(4, 3, 2, '0);
    do_cmd(5, 0, 9, 10'h3FF);
    check_eq("row9_ones", bus.video_memory[99:90], 10'h3FF);
    do_cmd(1, 10, 0, '0);
    do_cmd(4, 0, 12, '0);
    do_cmd(5, 0, 10, 10'h2AA);

    // Fill, then CLEAR with a SET held on cmd_valid throughout.
    for (int r = 0; r < ROWS; r++) do_cmd(5, 0, r, '1);
    check_eq("filled", bus.video_memory, {28'b0, {100{1'b1}}});
    @(negedge clk);
    bus.cmd_op = 3'd6; bus.cmd_valid = 1'b1;
    model_cmd(6, 0, 0, '0, e, p, lat);
    @(posedge clk); #1;
    bus.cmd_op = 3'd1; bus.cmd_x = 4'd1; bus.cmd_y = 4'd1;
    n = 0;
    while (!bus.cmd_ready && n < ROWS + 4) begin
      check_eq("clr_no_rsp", bus.rsp_valid, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    check_eq("clr_ready_low", n, ROWS);
    check_eq("clr_rsp", bus.rsp_valid, 1'b1);
    check_eq("clr_mem", bus.video_memory, '0);
    model_cmd(1, 1, 1, '0, e, p, lat);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check_eq("held_set_rsp", bus.rsp_valid, 1'b1);
    check_eq("held_set_mem", bus.video_memory, flat());
    @(posedge clk); #1;

    for (int r = 0; r < ROWS; r++) do_cmd(5, 0, r, 10'h001 << r);
    do_cmd(7, 0, 0, 10'h155);

    // Reset in the middle of a CLEAR.
    do_cmd(5, 0, 4, 10'h3C3);
    @(negedge clk);
    bus.cmd_op = 3'd6; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_eq("midrst_mem", bus.video_memory, '0);
    check_eq("midrst_out", {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_pixel, bus.rsp_err},
             5'b10000);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < ROWS + 2; i++) begin
      @(posedge clk); #1;
      check_eq("midrst_no_rsp", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    end

    for (int i = 0; i < 150; i++) begin
      int op;
      op = (($urandom_range(0, 15) == 0)) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
      do_cmd(op, $urandom_range(0, 11), $urandom_range(0, 11), COLS'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
